pack_fifo: RTL



---
 rtl/pack_fifo_pkg.sv | 7 +
 rtl/pack_fifo_cnt_lead.sv | 25 ++
 rtl/pack_fifo.sv | 96 +++++++++
 3 files changed

// File: rtl/pack_fifo_pkg.sv
// Shared constants for the packing FIFO: signal-level polarity encodings.
package pack_fifo_pkg;

   localparam logic HIGH = 1'b1;
   localparam logic LOW  = 1'b0;

endpackage

// File: rtl/pack_fifo_cnt_lead.sv
// Counts leading active lanes from lane 0, stopping at the first inactive lane.
module cnt_lead #(
   parameter int unsigned  IN  = 4,
   parameter logic         ACT = 1'b1,
   localparam int unsigned W   = $clog2(IN + 1)
) (
   input  logic [IN-1:0] vld_i,
   output logic [W-1:0]  num_o
);

   logic run;

   always_comb begin
      num_o = '0;
      run   = 1'b1;
      for (int i = 0; i < IN; i++) begin
         if (run && (vld_i[i] == ACT)) begin
            num_o = num_o + W'(1);
         end else begin
            run = 1'b0;
         end
      end
   end

endmodule

// File: rtl/pack_fifo.sv
// Circular buffer taking up to IN packed entries per cycle and exposing the oldest OUT for variable-count retirement.
module pack_fifo
   import pack_fifo_pkg::*;
#(
   parameter int unsigned  DATA  = 32,
   parameter int unsigned  IN    = 4,
   parameter int unsigned  OUT   = 4,
   parameter int unsigned  DEPTH = 16,
   parameter logic         ACT   = HIGH,
   localparam int unsigned CNT   = $clog2(DEPTH + 1),
   localparam int unsigned PNUM  = $clog2(OUT + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [IN-1:0][DATA-1:0]   in,
   input  logic [IN-1:0]             in_valid,
   output logic                      in_ready,
   output logic [OUT-1:0][DATA-1:0]  out,
   output logic [OUT-1:0]            out_valid,
   input  logic [PNUM-1:0]           pop_num,
   output logic [CNT-1:0]            count
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam int unsigned LW      = $clog2(IN + 1);
   localparam logic        ENABLE  = ACT;
   localparam logic        DISABLE = (ACT == HIGH) ? LOW : HIGH;

   logic [DATA-1:0] mem_q [DEPTH];
   logic [AW-1:0]   wp_q, wp_d;
   logic [AW-1:0]   rp_q, rp_d;
   logic [CNT-1:0]  count_q, count_d;

   logic [LW-1:0]   n_push;
   logic [LW-1:0]   n_push_acc;
   logic [CNT-1:0]  avail;
   logic [CNT-1:0]  n_pop;
   logic            ready_c;

   cnt_lead #(
      .IN  (IN),
      .ACT (ACT)
   ) u_cnt_lead (
      .vld_i (in_valid),
      .num_o (n_push)
   );

   // Ready uses registered occupancy only; same-cycle pops never grant space.
   always_comb begin
      ready_c    = (CNT'(DEPTH) - count_q) >= CNT'(IN);
      n_push_acc = ready_c ? n_push : '0;
      avail      = (count_q < CNT'(OUT)) ? count_q : CNT'(OUT);
      n_pop      = (CNT'(pop_num) < avail) ? CNT'(pop_num) : avail;
      wp_d       = wp_q + AW'(n_push_acc);
      rp_d       = rp_q + AW'(n_pop);
      count_d    = CNT'({1'b0, count_q} + (CNT+1)'(n_push_acc) - (CNT+1)'(n_pop));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   // Storage is not reset; lane writes wrap naturally through AW-bit addition.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < IN; i++) begin
            if (LW'(i) < n_push_acc) begin
               mem_q[wp_q + AW'(i)] <= in[i];
            end
         end
      end
   end

   always_comb begin
      out       = '0;
      out_valid = {OUT{DISABLE}};
      for (int k = 0; k < OUT; k++) begin
         if (CNT'(k) < avail) begin
            out[k]       = mem_q[rp_q + AW'(k)];
            out_valid[k] = ENABLE;
         end
      end
   end

   assign in_ready = ready_c ? ENABLE : DISABLE;
   assign count    = count_q;

endmodule
